// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared lane state encoding and default link constants
package serial_link_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lane_state_t;

  localparam logic [7:0] DEF_COMMA      = 8'hBC;
  localparam int         DEF_LOCK_COUNT = 4;
  localparam int         DEF_LOSS_COUNT = 3;

endpackage

// File: rtl/serial_parallel_lane.sv
// rtl/serial_parallel_lane.sv - one-lane deserialiser with comma hunt, lock check and loss detection
module serial_parallel_lane
  import serial_link_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
  parameter int               LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int               LOSS_COUNT = DEF_LOSS_COUNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             resync,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             active
);

  localparam int BW  = $clog2(WIDTH);
  localparam int LKW = $clog2(LOCK_COUNT + 1) + 1;
  localparam int LSW = $clog2(LOSS_COUNT + 1) + 1;

  localparam logic [BW-1:0]  LAST_BIT = BW'(WIDTH - 1);
  localparam logic [LKW-1:0] LOCK_N   = LKW'(LOCK_COUNT);
  localparam logic [LSW-1:0] LOSS_N   = LSW'(LOSS_COUNT);

  // Only the low WIDTH-1 history bits are ever observed, so the MSB is not kept.
  logic [WIDTH-2:0] sr;
  logic [BW-1:0]    bit_cnt, bit_d;
  logic [LKW-1:0]   lock_cnt, lock_d;
  logic [LSW-1:0]   loss_cnt, loss_d;
  lane_state_t      state, state_d;
  logic [WIDTH-1:0] data_d;
  logic             valid_d;

  logic [WIDTH-1:0] cand;
  logic             boundary;

  assign cand     = {sr, data_in};
  assign boundary = (bit_cnt == LAST_BIT);

  // Register the lane state; the shift register keeps sliding even during resync.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr       <= '0;
      bit_cnt  <= '0;
      lock_cnt <= '0;
      loss_cnt <= '0;
      state    <= HUNT;
      data     <= '0;
      valid    <= 1'b0;
      active   <= 1'b0;
    end else begin
      sr       <= cand[WIDTH-2:0];
      bit_cnt  <= bit_d;
      lock_cnt <= lock_d;
      loss_cnt <= loss_d;
      state    <= state_d;
      data     <= data_d;
      valid    <= valid_d;
      active   <= (state_d == LOCKED);
    end
  end

  // Next-state logic: comma hunt, lock confirmation, data emission and lock loss.
  always_comb begin
    state_d = state;
    bit_d   = boundary ? '0 : bit_cnt + BW'(1);
    lock_d  = lock_cnt;
    loss_d  = loss_cnt;
    data_d  = data;
    valid_d = 1'b0;
    if (resync) begin
      state_d = HUNT;
      bit_d   = '0;
      lock_d  = '0;
      loss_d  = '0;
    end else begin
      case (state)
        HUNT: begin
          if (cand == COMMA) begin
            bit_d   = '0;
            lock_d  = LKW'(1);
            state_d = (LOCK_COUNT == 1) ? LOCKED : CHECK;
          end
        end
        CHECK: begin
          if (boundary) begin
            if (cand == COMMA) begin
              lock_d = lock_cnt + LKW'(1);
              if (lock_d >= LOCK_N) state_d = LOCKED;
            end else begin
              lock_d  = '0;
              state_d = HUNT;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            if (cand != COMMA) begin
              data_d  = cand;
              valid_d = 1'b1;
            end else begin
              loss_d = '0;
            end
          end else if (cand == COMMA) begin
            if (loss_cnt + LSW'(1) >= LOSS_N) begin
              // Lock lost: this comma is taken as a fresh hunt match, so the
              // counter realigns to it and confirmation restarts at one.
              loss_d  = '0;
              bit_d   = '0;
              lock_d  = LKW'(1);
              state_d = CHECK;
            end else begin
              loss_d = loss_cnt + LSW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

endmodule

// File: rtl/serial_parallel_lanes.sv
// rtl/serial_parallel_lanes.sv - independent multi-lane serial-to-parallel receiver
module serial_parallel_lanes
  import serial_link_pkg::*;
#(
  parameter int               LANES      = 4,
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
  parameter int               LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int               LOSS_COUNT = DEF_LOSS_COUNT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       data_serial_in,
  input  logic [LANES-1:0]       resync,
  output logic [LANES*WIDTH-1:0] parallel_data,
  output logic [LANES-1:0]       valid_out,
  output logic [LANES-1:0]       active,
  output logic                   all_active
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    serial_parallel_lane #(
      .WIDTH      (WIDTH),
      .COMMA      (COMMA),
      .LOCK_COUNT (LOCK_COUNT),
      .LOSS_COUNT (LOSS_COUNT)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .data_in (data_serial_in[i]),
      .resync  (resync[i]),
      .data    (parallel_data[i*WIDTH +: WIDTH]),
      .valid   (valid_out[i]),
      .active  (active[i])
    );
  end

  assign all_active = &active;

endmodule

// File: tb/tb_serial_parallel_lanes.sv
// tb/tb_serial_parallel_lanes.sv - directed scoreboard bench for serial_parallel_lanes
module tb_serial_parallel_lanes;

  localparam logic [7:0] BC = 8'hBC;

  logic        clk;
  logic        reset;
  logic [3:0]  din;
  logic [3:0]  resync;
  logic [31:0] pdata;
  logic [3:0]  vout;
  logic [3:0]  active;
  logic        all_active;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base;

  logic       bq[4][$];
  logic [7:0] eq[4][$];
  int         st0[$];

  serial_parallel_lanes #(
    .LANES(4), .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .LOSS_COUNT(3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_serial_in (din),
    .resync         (resync),
    .parallel_data  (pdata),
    .valid_out      (vout),
    .active         (active),
    .all_active     (all_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bit(input int ln, input logic b);
    bq[ln].push_back(b);
  endtask

  task automatic push_sym(input int ln, input logic [7:0] s, input bit exp);
    for (int b = 7; b >= 0; b--) bq[ln].push_back(s[b]);
    if (exp) eq[ln].push_back(s);
  endtask

  task automatic tick(input logic [3:0] rs);
    logic [7:0] e;
    for (int l = 0; l < 4; l++) begin
      if (bq[l].size() != 0) din[l] = bq[l].pop_front();
      else din[l] = 1'b0;
    end
    resync = rs;
    @(posedge clk);
    #1;
    cyc++;
    resync = '0;
    for (int l = 0; l < 4; l++) begin
      if (vout[l]) begin
        check($sformatf("lane%0d_strobe_expected", l), 32'(eq[l].size() != 0), 32'd1);
        if (eq[l].size() != 0) begin
          e = eq[l].pop_front();
          check($sformatf("lane%0d_data", l), 32'(pdata[l*8 +: 8]), 32'(e));
        end
        if (l == 0) st0.push_back(cyc);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick(4'h0);
  endtask

  initial begin
    int exp_st[4];
    reset  = 1'b1;
    din    = '0;
    resync = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pdata", pdata, 32'h0);
    check("rst_valid", 32'(vout), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_all_active", 32'(all_active), 32'h0);
    reset = 1'b0;

    // Lock on lane 0, stream data, then idle commas while locked.
    base = cyc;
    for (int k = 0; k < 4; k++) push_sym(0, BC, 0);
    push_sym(0, 8'h5A, 1);
    push_sym(0, 8'h3C, 1);
    push_sym(0, 8'h11, 1);
    push_sym(0, BC, 0);
    push_sym(0, BC, 0);
    push_sym(0, 8'h22, 1);
    run(31);
    check("lock_active_before", 32'(active[0]), 32'h0);
    run(1);
    check("lock_active_at_4th", 32'(active[0]), 32'h1);
    check("lock_all_active_partial", 32'(all_active), 32'h0);
    run(38);
    check("idle_pdata_hold", 32'(pdata[7:0]), 32'h11);
    check("idle_active_stays", 32'(active[0]), 32'h1);
    run(10);
    check("lock_pending", 32'(eq[0].size()), 32'h0);
    check("lock_strobe_count", 32'(st0.size()), 32'd4);
    exp_st = '{40, 48, 56, 80};
    for (int k = 0; k < 4; k++)
      check($sformatf("strobe_cycle%0d", k), 32'((k < st0.size()) ? st0[k] - base : -1), 32'(exp_st[k]));
    tick(4'b0001);
    check("resync0_active", 32'(active[0]), 32'h0);

    // Reset in the middle of a symbol.
    for (int k = 0; k < 4; k++) push_sym(0, BC, 0);
    push_sym(0, 8'h5A, 0);
    run(35);
    check("midrst_locked_before", 32'(active[0]), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_pdata", pdata, 32'h0);
    check("midrst_valid", 32'(vout), 32'h0);
    check("midrst_active", 32'(active), 32'h0);
    check("midrst_all_active", 32'(all_active), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    bq[0].delete();
    eq[0].delete();
    tick(4'h0);
    check("midrst_hunt_after", 32'(active[0]), 32'h0);
    check("midrst_no_partial", pdata, 32'h0);

    // Unaligned start: a few stray bits ahead of the commas.
    for (int k = 0; k < 3; k++) push_bit(0, 1'($urandom_range(0, 1)));
    for (int k = 0; k < 4; k++) push_sym(0, BC, 0);
    push_sym(0, 8'hA5, 1);
    run(35);
    check("unaligned_lock", 32'(active[0]), 32'h1);
    run(8);
    check("unaligned_pending", 32'(eq[0].size()), 32'h0);
    tick(4'b0001);

    // Lock failure: a non-comma during confirmation restarts the hunt.
    push_sym(0, BC, 0);
    push_sym(0, BC, 0);
    push_sym(0, 8'h00, 0);
    for (int k = 0; k < 3; k++) push_sym(0, BC, 0);
    run(24);
    check("fail_active_low", 32'(active[0]), 32'h0);
    run(24);
    check("fail_restart_count", 32'(active[0]), 32'h0);
    push_sym(0, BC, 0);
    run(8);
    check("fail_relock", 32'(active[0]), 32'h1);
    tick(4'b0001);

    // Four lanes: lock all, slip lane 2 by one bit, relock it, resync lane 1.
    tick(4'hF);
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 4; k++) push_sym(l, BC, 0);
    for (int l = 0; l < 4; l++)
      if (l != 2)
        for (int k = 1; k <= 9; k++) push_sym(l, {4'(k), 4'(l)}, 1);
    push_sym(2, 8'h12, 1);
    push_bit(2, 1'b0);
    for (int k = 0; k < 3; k++) eq[2].push_back(8'h5E);
    for (int k = 0; k < 7; k++) push_sym(2, BC, 0);
    push_sym(2, 8'hA2, 1);
    run(31);
    check("ml_active_before", 32'(active), 32'h0);
    run(1);
    check("ml_active_all", 32'(active), 32'hF);
    check("ml_all_active", 32'(all_active), 32'h1);
    run(32);
    check("ml_lane2_before_loss", 32'(active[2]), 32'h1);
    run(1);
    check("ml_lane2_lost", 32'(active), 32'hB);
    check("ml_all_active_lost", 32'(all_active), 32'h0);
    run(23);
    check("ml_lane2_before_relock", 32'(active[2]), 32'h0);
    run(1);
    check("ml_lane2_relock", 32'(active), 32'hF);
    check("ml_all_active_relock", 32'(all_active), 32'h1);
    run(16);
    for (int l = 0; l < 4; l++)
      check($sformatf("ml_lane%0d_pending", l), 32'(eq[l].size()), 32'h0);
    tick(4'b0010);
    check("ml_resync1_active", 32'(active), 32'hD);
    check("ml_resync1_all_active", 32'(all_active), 32'h0);
    run(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
